// File: rtl/prog_load_pkg.sv
// Shared types and defaults for the UART program-upgrade loader.
// Holds the state encoding, the byte order of assembled words and the default limits.
package prog_load_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam bit BYTE_LSB_FIRST  = 1'b1;
  localparam int DEF_MAX_WORDS   = 16384;
  localparam int DEF_TIMEOUT_CYC = 10000000;

  // Byte lane within the 32-bit word for the idx-th received byte.
  function automatic logic [1:0] byte_lane(input logic [1:0] idx);
    return BYTE_LSB_FIRST ? idx : ~idx;
  endfunction

endpackage

// File: rtl/prog_load_timeout.sv
// Saturating idle counter: expire rises LIMIT enabled cycles after the last clear.
// No backpressure; LIMIT of 0 never expires.
module prog_load_timeout #(
  parameter int LIMIT = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          sat;

  assign sat    = (cnt_q == CW'(LIMIT));
  assign expire = (LIMIT != 0) && sat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !sat) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// UART program-upgrade sequencer: LEN_LO, LEN_HI, 4*N data bytes -> one-cycle upg_wen_o per word.
// Write issues one cycle after the 4th byte; no backpressure on rx. PROG_LOAD_CSUM_EN adds an XOR checksum byte.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int MAX_WORDS   = DEF_MAX_WORDS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              err_o,
  output logic              busy_o
);

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic [15:0] word_cnt_inc;
  logic [15:0] len_rx;
  logic [1:0]  idx_q;
  logic [31:0] shift_q;
  logic [31:0] word_next;
  logic        expire;
  logic        tmo_en;
  logic        byte_ok;
  logic        last_word;
`ifdef PROG_LOAD_CSUM_EN
  logic [7:0]  csum_q;
`endif

  assign word_cnt_inc = word_cnt_q + 16'd1;
  assign last_word    = (word_cnt_inc == len_q);
  assign len_rx       = {rx_data_i, len_q[7:0]};
  assign byte_ok      = rx_valid_i && !expire;
  assign tmo_en       = (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});

  always_comb begin
    word_next = shift_q;
    word_next[8*byte_lane(idx_q) +: 8] = rx_data_i;
  end

  prog_load_timeout #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (rx_valid_i || !tmo_en),
    .en    (tmo_en),
    .expire(expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (expire)          state_d = S_ERR;
        else if (rx_valid_i) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (expire) begin
          state_d = S_ERR;
        end else if (rx_valid_i) begin
          if (len_rx == 16'd0) begin
`ifdef PROG_LOAD_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_rx} > 17'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (expire)                             state_d = S_ERR;
        else if (rx_valid_i && idx_q == 2'd3)   state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef PROG_LOAD_CSUM_EN
          // A byte landing in the final WRITE is already the checksum.
          if (rx_valid_i) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
          else            state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROG_LOAD_CSUM_EN
      S_CSUM: begin
        if (expire)          state_d = S_ERR;
        else if (rx_valid_i) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        if (!start_i) state_d = S_IDLE;
      end
      S_ERR: begin
        if (!start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      err_o      <= 1'b0;
`ifdef PROG_LOAD_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            idx_q      <= '0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef PROG_LOAD_CSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_LEN_LO: if (byte_ok) len_q[7:0]  <= rx_data_i;
        S_LEN_HI: if (byte_ok) len_q[15:8] <= rx_data_i;
        S_DATA: begin
          if (byte_ok) begin
            shift_q[8*byte_lane(idx_q) +: 8] <= rx_data_i;
            idx_q <= idx_q + 2'd1;
`ifdef PROG_LOAD_CSUM_EN
            csum_q <= csum_q ^ rx_data_i;
`endif
            if (idx_q == 2'd3) begin
              upg_adr_o <= word_cnt_q[ADDR_W-1:0];
              upg_dat_o <= word_next;
            end
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_inc;
          // Keep a byte that arrives during the write as byte 0 of the next word.
          if (rx_valid_i && !last_word) begin
            shift_q[8*byte_lane(2'd0) +: 8] <= rx_data_i;
            idx_q <= 2'd1;
`ifdef PROG_LOAD_CSUM_EN
            csum_q <= csum_q ^ rx_data_i;
`endif
          end
        end
        default: ;
      endcase

      if (state_d == S_DONE && state_q != S_DONE) upg_done_o <= 1'b1;
      if (state_d == S_ERR && state_q != S_ERR) begin
        err_o      <= 1'b1;
        upg_done_o <= 1'b0;
      end
    end
  end

  assign upg_wen_o = (state_q == S_WRITE);
  assign upg_rst_o = (state_q == S_IDLE) || (state_q == S_ERR);
  assign busy_o    = !((state_q == S_IDLE) || (state_q == S_DONE));

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: scoreboard of expected writes, immediate-assert checks.
module tb_prog_load_ctrl;

  localparam int AW = 14;

  logic          clock;
  logic          reset;
  logic          start_i;
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          upg_rst_o;
  logic          upg_wen_o;
  logic [AW-1:0] upg_adr_o;
  logic [31:0]   upg_dat_o;
  logic          upg_done_o;
  logic          err_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int wen_base;
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  adr_exp;
  logic [7:0]     csum;
  logic           prev_wen = 1'b0;

  prog_load_ctrl #(
    .ADDR_W     (AW),
    .MAX_WORDS  (16384),
    .TIMEOUT_CYC(100)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_i   (start_i),
    .rx_valid_i(rx_valid_i),
    .rx_data_i (rx_data_i),
    .upg_rst_o (upg_rst_o),
    .upg_wen_o (upg_wen_o),
    .upg_adr_o (upg_adr_o),
    .upg_dat_o (upg_dat_o),
    .upg_done_o(upg_done_o),
    .err_o     (err_o),
    .busy_o    (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clock) begin
    if (upg_wen_o) begin
      wen_cnt++;
      check("wen_consecutive", 64'(prev_wen), 64'd0);
      check("wen_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wen_adr", 64'(upg_adr_o), 64'(e[AW+31:32]));
        check("wen_dat", 64'(upg_dat_o), 64'(e[31:0]));
      end
    end
    prev_wen = upg_wen_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clock);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n, input int gap);
    send_byte(n[7:0]);
    tick(gap);
    send_byte(n[15:8]);
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    exp_q.push_back({adr_exp, w});
    adr_exp++;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      csum ^= w[8*i +: 8];
      tick(gap);
    end
  endtask

  task automatic begin_load();
    start_i  = 1'b1;
    tick(1);
    adr_exp  = '0;
    csum     = 8'h00;
    wen_base = wen_cnt;
  endtask

  task automatic finish_load();
`ifdef PROG_LOAD_CSUM_EN
    send_byte(csum);
`endif
    tick(3);
  endtask

  task automatic end_load();
    start_i = 1'b0;
    tick(2);
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    adr_exp    = '0;
    csum       = 8'h00;
    wen_base   = 0;
    tick(3);
    @(negedge clock);
    check("rst_upg_rst", 64'(upg_rst_o), 64'd1);
    check("rst_wen", 64'(upg_wen_o), 64'd0);
    check("rst_adr", 64'(upg_adr_o), 64'd0);
    check("rst_dat", 64'(upg_dat_o), 64'd0);
    check("rst_done", 64'(upg_done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick(2);

    // Basic two-word image with idle gaps between bytes.
    begin_load();
    check("basic_busy", 64'(busy_o), 64'd1);
    check("basic_upg_rst_low", 64'(upg_rst_o), 64'd0);
    send_len(16'd2, 1);
    send_word(32'h0000_0013, 1);
    send_word(32'h0302_0100, 1);
    finish_load();
    check("basic_wens", 64'(wen_cnt - wen_base), 64'd2);
    check("basic_done", 64'(upg_done_o), 64'd1);
    check("basic_upg_rst", 64'(upg_rst_o), 64'd0);
    check("basic_err", 64'(err_o), 64'd0);
    check("basic_busy_done", 64'(busy_o), 64'd0);
    end_load();
    check("idle_done_held", 64'(upg_done_o), 64'd1);
    check("idle_upg_rst", 64'(upg_rst_o), 64'd1);

    // Zero-length image.
    begin_load();
    check("zero_done_cleared", 64'(upg_done_o), 64'd0);
    send_len(16'd0, 0);
    finish_load();
    check("zero_wens", 64'(wen_cnt - wen_base), 64'd0);
    check("zero_done", 64'(upg_done_o), 64'd1);
    check("zero_err", 64'(err_o), 64'd0);
    end_load();

    // Oversized image length.
    begin_load();
    send_len(16'h4001, 0);
    tick(2);
    check("big_err", 64'(err_o), 64'd1);
    check("big_upg_rst", 64'(upg_rst_o), 64'd1);
    check("big_done", 64'(upg_done_o), 64'd0);
    check("big_wens", 64'(wen_cnt - wen_base), 64'd0);
    end_load();
    check("big_err_sticky", 64'(err_o), 64'd1);

    // Timeout after two data bytes.
    begin_load();
    check("tmo_err_cleared", 64'(err_o), 64'd0);
    send_len(16'd1, 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    cyc = 0;
    while (!err_o && cyc < 150) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (cyc == 90) check("tmo_err_early", 64'(err_o), 64'd0);
    end
    check("tmo_err_set", 64'(err_o), 64'd1);
    check("tmo_cycle_window", 64'(cyc >= 95 && cyc <= 110), 64'd1);
    check("tmo_wens", 64'(wen_cnt - wen_base), 64'd0);
    #1;
    end_load();
    begin_load();
    check("tmo_err_toggle_clear", 64'(err_o), 64'd0);

    // Back-to-back bytes, a byte lands in each WRITE cycle.
    send_len(16'd3, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0123_4567, 0);
    send_word(32'hA5A5_5A5A, 0);
    finish_load();
    check("b2b_wens", 64'(wen_cnt - wen_base), 64'd3);
    check("b2b_done", 64'(upg_done_o), 64'd1);
    check("b2b_err", 64'(err_o), 64'd0);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    end_load();

    // Reset in the middle of the second word, then a fresh load.
    begin_load();
    send_len(16'd3, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_upg_rst", 64'(upg_rst_o), 64'd1);
    check("mid_rst_wen", 64'(upg_wen_o), 64'd0);
    check("mid_rst_adr", 64'(upg_adr_o), 64'd0);
    check("mid_rst_dat", 64'(upg_dat_o), 64'd0);
    check("mid_rst_done", 64'(upg_done_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_wens", 64'(wen_cnt - wen_base), 64'd1);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    start_i = 1'b0;
    tick(2);
    begin_load();
    send_len(16'd2, 0);
    send_word(32'hCAFE_F00D, 2);
    send_word(32'h8000_0001, 0);
    finish_load();
    check("fresh_wens", 64'(wen_cnt - wen_base), 64'd2);
    check("fresh_done", 64'(upg_done_o), 64'd1);
    end_load();

`ifdef PROG_LOAD_CSUM_EN
    // Corrupted checksum byte.
    begin_load();
    send_len(16'd1, 0);
    send_word(32'h0F0E_0D0C, 1);
    csum = ~csum;
    tick(1);
    finish_load();
    check("csum_bad_err", 64'(err_o), 64'd1);
    check("csum_bad_done", 64'(upg_done_o), 64'd0);
    check("csum_bad_upg_rst", 64'(upg_rst_o), 64'd1);
    end_load();
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Sequences the UART program-upgrade path of the instruction ROM (prgrom) and data memory.
- Consumes a byte stream from the UART receiver and assembles 32-bit little-endian words.
- Drives the upg_* write port (rst/wen/adr/dat/done) that the fetch stage muxes against normal CPU fetch.
- Holds the CPU in upgrade mode until the image is loaded, then releases it by asserting done.

Parameters:
- ADDR_W, 14, word-address width of the upg_adr_o bus (matches the 14-bit prgrom address).
- MAX_WORDS, 16384, largest accepted image in words; must be ≤ 2**ADDR_W.
- TIMEOUT_CYC, 10000000, idle cycles between bytes before abort (0 disables the timeout).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  level request to enter upgrade mode (debounced switch); sampled in IDLE only.
- rx_valid_i  in  1  one-cycle strobe, a received byte is on rx_data_i.
- rx_data_i  in  8  received byte.
- upg_rst_o  out  1  high while NOT in upgrade mode (CPU runs from ROM).
- upg_wen_o  out  1  one-cycle memory write strobe.
- upg_adr_o  out  ADDR_W  word address of the current write.
- upg_dat_o  out  32  write data.
- upg_done_o  out  1  image fully written; stays high until the next start.
- err_o  out  1  sticky error flag (bad length, timeout, checksum); cleared on next start.
- busy_o  out  1  high in any state other than IDLE/DONE.

Behaviour:
- Reset values:
  - upg_rst_o=1, upg_done_o=0, all other outputs 0.
  - State=IDLE, word counter=0, byte index=0, timeout counter=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little endian), then 4·N data bytes, each word sent LSB first.
- States:
  - IDLE: upg_rst_o=1. On start_i=1 → LEN_LO; clear err_o, upg_done_o and counters; drop upg_rst_o to 0 on the same transition.
  - LEN_LO: on rx_valid_i, latch len[7:0] → LEN_HI.
  - LEN_HI: on rx_valid_i, latch len[15:8] and evaluate N:
    - N==0 → DONE.
    - N>MAX_WORDS → ERR.
    - Otherwise → DATA.
  - DATA: on rx_valid_i, shift the byte into shift[8*idx +: 8] and increment idx (2-bit). When idx wraps from 3 → WRITE.
  - WRITE (exactly 1 cycle):
    - upg_wen_o=1, upg_adr_o=word counter, upg_dat_o=assembled word.
    - Then word counter +1. If new counter==N → DONE, else → DATA.
    - A rx_valid_i arriving in WRITE must not be lost: register it as the byte 0 of the next word.
  - DONE: upg_done_o=1, upg_rst_o=0. Returns to IDLE when start_i falls to 0; upg_done_o stays 1 in IDLE until the next start.
  - ERR: err_o=1, upg_done_o=0, upg_rst_o=1 (CPU not released on a corrupt image). start_i low → IDLE.
- Timeout:
  - Counts cycles without rx_valid_i while in LEN_LO, LEN_HI or DATA; resets on each byte.
  - Reaching TIMEOUT_CYC → ERR.
  - Saturates; never wraps.
- upg_adr_o/upg_dat_o hold their last value outside WRITE. upg_wen_o is never high for two consecutive cycles.
- Bytes received in IDLE, DONE or ERR are ignored.
- start_i deasserted mid-load: ignored; only the timeout or frame completion ends a load.
- reset asserted mid-load: immediate return to reset values. Partially written ROM contents are not the block's concern.
- Word counter is 16 bits; comparisons use the full 16 bits, with upg_adr_o = counter[ADDR_W-1:0].

Optional Feature:
- PROG_LOAD_CSUM_EN defined:
  - After the last data byte, one extra byte is expected: the XOR of all data bytes (state CSUM follows the final WRITE instead of DONE).
  - Mismatch → ERR; match → DONE.
  - N==0 still expects a checksum byte of 0x00.
  - The timeout applies in CSUM.
- Not defined: no CSUM state; the final WRITE goes straight to DONE.

Decomposition:
- Shared package prog_load_pkg holds:
  - the state encoding localparams (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR);
  - the byte-order constant;
  - the default MAX_WORDS and TIMEOUT_CYC.
- One natural sub-module: prog_load_timeout, a saturating idle counter with clear/enable inputs and an expire output.

Test Plan:
- Reset then start_i=1, send 02 00 | 13 00 00 00 | 00 01 02 03 → two wen pulses:
  - adr 0 dat 0x00000013;
  - adr 1 dat 0x03020100;
  - then upg_done_o=1, upg_rst_o=0, err_o=0.
- Send LEN=0x0000 → DONE with zero wen pulses (with CSUM_EN, send 00 first).
- Send LEN=0x4001 (>16384) → err_o=1, upg_rst_o=1, no wen.
- Send LEN=1 and 2 bytes, then idle for TIMEOUT_CYC (bench uses 100) → err_o=1 at cycle 100; a later start_i toggle clears err_o.
- Issue back-to-back bytes with rx_valid_i asserted during the WRITE cycle, N=3 → three correct words, no dropped byte.
- Assert reset in DATA after word 1 → all outputs return to reset values; a fresh full load then succeeds from adr 0.
- CSUM_EN: checksum byte correct → DONE; corrupt the checksum byte → ERR.
